// File: rtl/mux_pkg.sv
// Shared constants for the streaming channel multiplexer.
//   MODE_SEL / MODE_RR : values of the mode input (select-driven / round-robin)
//   DEFAULT_WIDTH      : default data width per channel
//   DEFAULT_NCH        : default number of input channels
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_NCH   = 4;

endpackage

// File: rtl/mux_stream_rr_if.sv
// Stream bundle between NCH upstream channels, the multiplexer and one downstream sink.
//   in_valid  [NCH]        : per-channel data valid
//   in_data   [NCH*WIDTH]  : channel i at [i*WIDTH +: WIDTH]
//   in_ready  [NCH]        : per-channel accept strobe (one-hot or zero)
//   out_valid              : output register holds a word
//   out_data  [WIDTH]      : registered selected word
//   out_ch    [SELW]       : channel that supplied out_data
//   out_ready              : downstream accept
// master = multiplexer view, slave = environment view.
interface mux_stream_rr_if
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NCH   = DEFAULT_NCH,
    parameter int unsigned SELW  = $clog2(NCH)
);

    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_ready;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester searching upward from
// (ptr+1) mod NCH, wrapping past NCH-1 to 0.
//   req     [NCH]  : request vector
//   ptr     [SELW] : last granted channel
//   gnt_idx [SELW] : granted channel index (0 when none)
//   gnt_any        : some channel granted
module rr_arbiter #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    // Scan offsets 1..NCH; the first hit keeps the grant.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = (32'(ptr) + k) % NCH;
            if (!gnt_any && req[SELW'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_stream_rr.sv
// NCH-to-1 stream multiplexer with a single output register stage.
// mode=0 forwards the channel addressed by sel; mode=1 arbitrates round-robin.
//   clk, rst_n : clock, synchronous active-low reset
//   mode       : 0 select-driven, 1 round-robin
//   sel [SELW] : channel index used in select mode
//   bus        : stream bundle (master view)
module mux_stream_rr
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NCH   = DEFAULT_NCH,
    parameter int unsigned SELW  = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    mux_stream_rr_if.master bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic             sel_ok;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_any;
    logic             load;
    logic [WIDTH-1:0] gnt_data;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // Select path and grant muxing; reset gates load so in_ready stays low.
    always_comb begin
        sel_ok = 1'b0;
        if (32'(sel) < NCH) begin
            sel_ok = bus.in_valid[sel];
        end
        gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
        gnt_any  = (mode == MODE_RR) ? rr_any : sel_ok;
        load     = rst_n & gnt_any & (~out_valid_q | bus.out_ready);
        gnt_data = bus.in_data[32'(gnt_idx) * WIDTH +: WIDTH];
    end

    assign bus.in_ready  = load ? (NCH'(1) << gnt_idx) : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

    // Output register next state: load replaces, drain without load empties.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            if (mode == MODE_RR) begin
                ptr_d = gnt_idx;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Reset points ptr at NCH-1 so channel 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= SELW'(NCH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule

// File: tb/tb_mux_stream_rr.sv
// Self-checking bench for mux_stream_rr: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_mux_stream_rr;
    import mux_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          mode;
    logic [SW-1:0] sel;

    mux_stream_rr_if #(.WIDTH(W), .NCH(N)) bus ();

    mux_stream_rr #(.WIDTH(W), .NCH(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict the grant from the rules, check in_ready before the
    // edge, advance the model at the edge, check the output register after it.
    task automatic cycle();
        bit           any;
        int           g;
        bit           ld;
        logic [N-1:0] exp_rdy;
        #1;
        any = 0;
        g   = 0;
        if (mode == MODE_SEL) begin
            if (int'(sel) < N && bus.in_valid[sel]) begin
                any = 1;
                g   = int'(sel);
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!any && bus.in_valid[c]) begin
                    any = 1;
                    g   = c;
                end
            end
        end
        ld      = rst_n && any && (!m_valid || bus.out_ready);
        exp_rdy = ld ? (N'(1) << g) : '0;
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = N - 1;
        end else if (ld) begin
            m_valid = 1;
            m_data  = bus.in_data[g*W +: W];
            m_ch    = g;
            if (mode == MODE_RR) m_ptr = g;
        end else if (bus.out_ready) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        check("out_data",  64'(bus.out_data),  64'(m_data));
        check("out_ch",    64'(bus.out_ch),    64'(m_ch));
    endtask

    logic [W-1:0] pat [N];

    initial begin
        m_valid = 0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = N - 1;

        pat[0] = 32'hAAAA_AAAA;
        pat[1] = 32'h5555_5555;
        pat[2] = 32'h0000_0000;
        pat[3] = 32'hFFFF_FFFF;

        // Reset held two cycles with every channel valid
        rst_n         = 1'b0;
        mode          = MODE_SEL;
        sel           = '0;
        bus.in_valid  = '1;
        bus.in_data   = {pat[3], pat[2], pat[1], pat[0]};
        bus.out_ready = 1'b1;
        repeat (2) cycle();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);

        // Select mode stepping sel 0..3
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = SW'(i);
            cycle();
            check("sel_data", 64'(bus.out_data), 64'(pat[i]));
        end

        // Round-robin, all valid, continuous drain
        mode = MODE_RR;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("rr_seq_ch",    64'(bus.out_ch),    64'(i % 4));
            check("rr_seq_valid", 64'(bus.out_valid), 64'd1);
        end

        // Backpressure after a load of ch1
        cycle();
        cycle();
        check("bp_load_ch1", 64'(bus.out_ch), 64'd1);
        bus.out_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("bp_hold_ch",    64'(bus.out_ch),   64'd1);
            check("bp_hold_data",  64'(bus.out_data), 64'(pat[1]));
            check("bp_in_ready",   64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        cycle();
        check("bp_next_ch2", 64'(bus.out_ch), 64'd2);

        // Sparse requesters 0 and 3 from a fresh reset
        rst_n = 1'b0;
        cycle();
        rst_n        = 1'b1;
        bus.in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("sparse_ch", 64'(bus.out_ch), (i % 2 == 0) ? 64'd0 : 64'd3);
        end

        // Select an idle channel: nothing loads, the held word drains
        mode = MODE_SEL;
        sel  = 2'd2;
        cycle();
        check("idle_sel_drain", 64'(bus.out_valid), 64'd0);

        // Reset while a word is held under backpressure
        mode          = MODE_RR;
        bus.in_valid  = '1;
        bus.out_ready = 1'b0;
        cycle();
        cycle();
        check("held_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        cycle();
        check("rst_discard", 64'(bus.out_valid), 64'd0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        check("post_rst_ch0", 64'(bus.out_ch), 64'd0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(0, 31) != 0);
            mode         = ($urandom_range(0, 2) != 0) ? MODE_RR : MODE_SEL;
            sel          = SW'($urandom_range(0, N - 1));
            bus.in_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int c = 0; c < N; c++) begin
                bus.in_data[c*W +: W] = $urandom();
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
